// File: rtl/grid_sequencer.sv
// Sequences grid generation attempts: reset, settle, start, wait, retrying with new seeds.
// Optional per-attempt watchdog enabled by defining GRID_SEQUENCER_TIMEOUT_EN.
module grid_sequencer #(
    parameter int unsigned LFSR_WIDTH     = 8,
    parameter int unsigned MAX_TRIES      = 16,
    parameter int unsigned SETTLE_CYCLES  = 28,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req,
    output logic                  req_ready,
    input  logic [LFSR_WIDTH-1:0] seed_init,
    output logic                  grid_reset,
    output logic                  grid_rq_start,
    output logic [LFSR_WIDTH-1:0] grid_seed,
    input  logic                  grid_done,
    input  logic                  grid_success,
    output logic                  busy,
    output logic                  done,
    output logic                  success,
    output logic [7:0]            tries,
    output logic                  timed_out
);

    localparam int unsigned SettleW = $clog2(SETTLE_CYCLES + 1);

    if (MAX_TRIES < 1 || MAX_TRIES > 255 || SETTLE_CYCLES == 0 || TIMEOUT_CYCLES == 0) begin : g_bad
        $error("grid_sequencer: parameter out of range");
    end

    typedef enum logic [2:0] {StIdle, StGrst, StSettle, StStart, StWait, StReport} state_e;

    state_e                  state_q, state_d;
    logic [LFSR_WIDTH-1:0]   seed_q, seed_d, seed_inc;
    logic [7:0]              tries_q, tries_d;
    logic                    success_q, success_d;
    logic [SettleW-1:0]      settle_q, settle_d;
    logic                    settle_last, last_try, timeout_hit, attempt_fail, accept;

    assign accept       = (state_q == StIdle) && req;
    assign settle_last  = (settle_q == SettleW'(SETTLE_CYCLES - 1));
    assign last_try     = (tries_q >= 8'(MAX_TRIES));
    assign attempt_fail = (state_q == StWait) && ((grid_done && !grid_success) || timeout_hit);
    assign seed_inc     = seed_q + 1'b1;

`ifdef GRID_SEQUENCER_TIMEOUT_EN
    localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WaitW-1:0] wait_q, wait_d;
    logic             timed_out_q, timed_out_d;

    // A completion in the same cycle as expiry wins over the watchdog.
    assign timeout_hit = (state_q == StWait) && !grid_done &&
                         (wait_q == WaitW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wait_d      = (state_q == StWait) ? wait_q + 1'b1 : '0;
        timed_out_d = timed_out_q;
        if (accept) timed_out_d = 1'b0;
        if (timeout_hit) timed_out_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_q      <= '0;
            timed_out_q <= 1'b0;
        end else begin
            wait_q      <= wait_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign timed_out = timed_out_q;
`else
    assign timeout_hit = 1'b0;
    assign timed_out   = 1'b0;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (req) state_d = StGrst;
            StGrst:   state_d = StSettle;
            StSettle: if (settle_last) state_d = StStart;
            StStart:  state_d = StWait;
            StWait: begin
                if (grid_done && grid_success) state_d = StReport;
                else if (attempt_fail)         state_d = last_try ? StReport : StGrst;
            end
            StReport: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Output logic; reset gates the pulses so an abandoned attempt never reports.
    always_comb begin
        req_ready     = (state_q == StIdle);
        busy          = (state_q != StIdle);
        grid_reset    = reset || (state_q == StGrst);
        grid_rq_start = !reset && (state_q == StStart);
        done          = !reset && (state_q == StReport);
    end

    always_comb begin
        seed_d    = seed_q;
        tries_d   = tries_q;
        success_d = success_q;
        settle_d  = (state_q == StSettle) ? settle_q + 1'b1 : '0;
        if (accept) begin
            seed_d    = (seed_init == '0) ? LFSR_WIDTH'(1) : seed_init;
            tries_d   = '0;
            success_d = 1'b0;
        end
        if (state_q == StGrst) tries_d = tries_q + 8'd1;
        if (state_q == StWait && grid_done && grid_success) success_d = 1'b1;
        // Seed zero is a stuck LFSR state, so the wrap skips it.
        if (attempt_fail && !last_try) seed_d = (seed_inc == '0) ? LFSR_WIDTH'(1) : seed_inc;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            seed_q    <= LFSR_WIDTH'(1);
            tries_q   <= '0;
            success_q <= 1'b0;
            settle_q  <= '0;
        end else begin
            seed_q    <= seed_d;
            tries_q   <= tries_d;
            success_q <= success_d;
            settle_q  <= settle_d;
        end
    end

    assign grid_seed = seed_q;
    assign tries     = tries_q;
    assign success   = success_q;

endmodule

// File: tb/tb_grid_sequencer.sv
// Self-checking bench for grid_sequencer with a cycle-stepped grid model and request-level reference.
module tb_grid_sequencer;

    localparam int unsigned LW = 8;
    localparam int unsigned MT = 4;
    localparam int unsigned SC = 28;
    localparam int unsigned TC = 100;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req = 1'b0;
    logic [LW-1:0] seed_init = '0;
    logic          grid_done = 1'b0;
    logic          grid_success = 1'b0;
    logic          req_ready, grid_reset, grid_rq_start, busy, done, success, timed_out;
    logic [LW-1:0] grid_seed;
    logic [7:0]    tries;

    grid_sequencer #(
        .LFSR_WIDTH    (LW),
        .MAX_TRIES     (MT),
        .SETTLE_CYCLES (SC),
        .TIMEOUT_CYCLES(TC)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .req_ready    (req_ready),
        .seed_init    (seed_init),
        .grid_reset   (grid_reset),
        .grid_rq_start(grid_rq_start),
        .grid_seed    (grid_seed),
        .grid_done    (grid_done),
        .grid_success (grid_success),
        .busy         (busy),
        .done         (done),
        .success      (success),
        .tries        (tries),
        .timed_out    (timed_out)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Grid model state
    int          cnt = -1;
    bit          att_ok = 1'b0;
    int          fail_left = 0;
    bit          never_done = 1'b0;
    int          delay_cfg = 1;
    logic [7:0]  seeds_seen[$];
    int          rst_pulses = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample away from the edge, and let the grid model react.
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (grid_reset) begin
            if (!reset) rst_pulses++;
            cnt          = -1;
            grid_done    = 1'b0;
            grid_success = 1'b0;
        end else if (grid_rq_start) begin
            seeds_seen.push_back(grid_seed);
            att_ok = (fail_left == 0);
            if (fail_left > 0) fail_left--;
            cnt = never_done ? -2 : delay_cfg;
        end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                grid_done    = 1'b1;
                grid_success = att_ok;
            end
        end
    endtask

    // Seeds walk through 1..255 cyclically, starting at the (zero-corrected) initial seed.
    function automatic logic [7:0] exp_seed(input logic [7:0] s, input int k);
        int s0;
        s0 = (s == 8'd0) ? 1 : int'(s);
        return 8'(((s0 - 1 + k) % 255) + 1);
    endfunction

    task automatic run_req(input logic [7:0] seed, input int nf, input int dly, input bit nd,
                           input bit hold, input string tag);
        int acc;
        int budget;
        int exp_tries;
        bit exp_ok;
        fail_left  = nf;
        delay_cfg  = dly;
        never_done = nd;
        seeds_seen.delete();
        rst_pulses = 0;
        done_cnt   = 0;
        budget     = 0;
        while (!req_ready && budget < 100) begin
            step();
            budget++;
        end
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        req       = 1'b1;
        seed_init = seed;
        acc       = cyc;
        step();
        if (!hold) req = 1'b0;
        seed_init = ~seed;
        chk({tag, "_seed0"}, 32'(grid_seed), 32'(exp_seed(seed, 0)));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_notready"}, 32'(req_ready), 32'd0);
        budget = 0;
        while (done_cnt == 0 && budget < 3000) begin
            step();
            budget++;
        end
        req = 1'b0;
        exp_ok    = !nd && (nf < int'(MT));
        exp_tries = exp_ok ? nf + 1 : int'(MT);
        chk({tag, "_done"}, 32'(done_cnt), 32'd1);
        chk({tag, "_success"}, 32'(success), 32'(exp_ok));
        chk({tag, "_tries"}, 32'(tries), 32'(exp_tries));
        chk({tag, "_timed_out"}, 32'(timed_out), 32'(nd));
        if (exp_ok && nf == 0) chk({tag, "_latency"}, 32'(done_cyc - acc), 32'(3 + SC + dly));
        chk({tag, "_grid_resets"}, 32'(rst_pulses), 32'(exp_tries));
        chk({tag, "_starts"}, 32'(seeds_seen.size()), 32'(exp_tries));
        for (int k = 0; k < seeds_seen.size() && k < exp_tries; k++)
            chk({tag, "_seed_seq"}, 32'(seeds_seen[k]), 32'(exp_seed(seed, k)));
        repeat (3) step();
        chk({tag, "_single_done"}, 32'(done_cnt), 32'd1);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_ready_after"}, 32'(req_ready), 32'd1);
        chk({tag, "_success_hold"}, 32'(success), 32'(exp_ok));
        chk({tag, "_tries_hold"}, 32'(tries), 32'(exp_tries));
    endtask

    initial begin
        int budget;
        repeat (3) step();
        reset = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grid_seed", 32'(grid_seed), 32'd1);
        chk("rst_tries", 32'(tries), 32'd0);
        chk("rst_success", 32'(success), 32'd0);
        chk("rst_timed_out", 32'(timed_out), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rq_start", 32'(grid_rq_start), 32'd0);
        chk("rst_grid_reset", 32'(grid_reset), 32'd0);

        run_req(8'h5A, 0, 40, 1'b0, 1'b0, "first_try");
        run_req(8'hFF, 2, 17, 1'b0, 1'b0, "wrap_retry");
        run_req(8'h10, 9, 5, 1'b0, 1'b0, "all_fail");
        run_req(8'h00, 0, 12, 1'b0, 1'b1, "zero_seed_hold");
`ifdef GRID_SEQUENCER_TIMEOUT_EN
        run_req(8'h77, 0, 1, 1'b1, 1'b0, "watchdog");
`endif

        // Reset while waiting on the grid
        fail_left  = 0;
        never_done = 1'b1;
        seeds_seen.delete();
        done_cnt   = 0;
        req        = 1'b1;
        seed_init  = 8'h33;
        step();
        req    = 1'b0;
        budget = 0;
        while (seeds_seen.size() == 0 && budget < 100) begin
            step();
            budget++;
        end
        repeat (3) step();
        chk("midrst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_grid_reset", 32'(grid_reset), 32'd1);
        step();
        reset = 1'b0;
        #1;
        chk("midrst_ready", 32'(req_ready), 32'd1);
        chk("midrst_busy_low", 32'(busy), 32'd0);
        chk("midrst_tries", 32'(tries), 32'd0);
        chk("midrst_seed", 32'(grid_seed), 32'd1);
        repeat (5) step();
        chk("midrst_no_done", 32'(done_cnt), 32'd0);
        chk("midrst_grid_reset_low", 32'(grid_reset), 32'd0);
        never_done = 1'b0;

        for (int i = 0; i < 6; i++)
            run_req(8'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(1, 30)), 1'b0,
                    1'($urandom_range(0, 1)), "random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/grid_sequencer.md
GRID_SEQUENCER -- requirements
Module: grid_sequencer

Interface
REQ-001 SHALL have parameter LFSR_WIDTH, default 8, seed width matching the grid LFSR.
REQ-002 SHALL have parameter MAX_TRIES, default 16, the maximum grid attempts per request (range 1..255).
REQ-003 SHALL have parameter SETTLE_CYCLES, default 28, cycles waited after grid reset before start (must exceed 3*GRID_LEN).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 65535, the per-attempt watchdog limit.
REQ-005 SHALL have port clock, input, 1, clock for all state.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port req, input, 1, generation request, accepted when req && req_ready.
REQ-008 SHALL have port req_ready, output, 1, high only in IDLE.
REQ-009 SHALL have port seed_init, input, LFSR_WIDTH, the seed captured on acceptance.
REQ-010 SHALL have port grid_reset, output, 1, drives grid reset.
REQ-011 SHALL have port grid_rq_start, output, 1, drives grid rq_start.
REQ-012 SHALL have port grid_seed, output, LFSR_WIDTH, drives grid seed, registered.
REQ-013 SHALL have port grid_done, input, 1, the grid done flag.
REQ-014 SHALL have port grid_success, input, 1, the grid success flag.
REQ-015 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-016 SHALL have port done, output, 1, a one-cycle pulse when a request completes.
REQ-017 SHALL have port success, output, 1, the result of the last completed request.
REQ-018 SHALL have port tries, output, 8, the count of attempts used by the last or current request.
REQ-019 SHALL have port timed_out, output, 1, sticky per request; set if any attempt hit the watchdog.

Function
REQ-020 SHALL implement states IDLE, GRST, SETTLE, START, WAIT, REPORT.
REQ-021 IDLE: on accept, SHALL capture seed_init into grid_seed (0 replaced by 1), clear tries/success/timed_out, and go to GRST.
REQ-022 GRST: SHALL assert grid_reset for exactly 1 cycle, increment tries, and go to SETTLE.
REQ-023 SETTLE: SHALL count SETTLE_CYCLES cycles, then go to START.
REQ-024 START: SHALL assert grid_rq_start for exactly 1 cycle, then go to WAIT.
REQ-025 WAIT: on grid_done && grid_success, SHALL set success=1 and go to REPORT.
REQ-026 WAIT: on grid_done && !grid_success with tries < MAX_TRIES, SHALL set grid_seed = grid_seed+1 (0 after wrap replaced by 1) and go to GRST.
REQ-027 WAIT: on grid_done && !grid_success with tries == MAX_TRIES, SHALL go to REPORT with success=0.
REQ-028 REPORT: SHALL assert done for 1 cycle, then go to IDLE; success/tries/timed_out SHALL hold until the next accept.
REQ-029 grid_reset SHALL be reset OR (state==GRST), combinational, so the grid is reset alongside the sequencer.
REQ-030 req SHALL be ignored outside IDLE; no queuing.
REQ-031 End-to-end latency for a first-try success SHALL be 1+1+SETTLE_CYCLES+1+N cycles from accept to done, where N is the grid solve time.

Reset
REQ-032 On reset, SHALL set state=IDLE, grid_seed=1, tries=0, success=0, timed_out=0, done=0, grid_rq_start=0, busy=0, and req_ready=1 from the first cycle after reset deasserts.
REQ-033 Reset mid-operation SHALL abandon the attempt with no done pulse.

Configuration
REQ-034 With GRID_SEQUENCER_TIMEOUT_EN defined, a WAIT-cycle counter reaching TIMEOUT_CYCLES SHALL set timed_out and be handled as a grid failure (REQ-026/027).
REQ-035 Without GRID_SEQUENCER_TIMEOUT_EN, there SHALL be no watchdog counter, timed_out SHALL be tied 0, and WAIT SHALL exit only on grid_done.

Verification
REQ-036 seed_init=0x5A, grid model succeeds 40 cycles after start -> grid_seed=0x5A, one grid_reset pulse, done pulse, success=1, tries=1.
REQ-037 seed_init=0xFF, model fails twice then succeeds -> seeds 0xFF, 0x01, 0x02 used in order; success=1, tries=3.
REQ-038 MAX_TRIES=4, model always fails -> 4 grid_reset pulses, done pulse, success=0, tries=4.
REQ-039 seed_init=0x00 -> grid_seed=0x01; req held high while busy -> no second accept until after done.
REQ-040 TIMEOUT_EN, TIMEOUT_CYCLES=100, model never sets done, MAX_TRIES=2 -> 2 attempts, done pulse, success=0, timed_out=1.
REQ-041 Reset asserted during WAIT -> grid_reset high same cycle, IDLE next cycle, no done pulse, req_ready=1.
